// File: rtl/can_dlc_payload_tracker.sv
// Latches the DLC, decodes it to a clamped payload length and CRC select, then counts data bytes to completion.
// Latency: length/CRC one cycle after dlc_valid_i; no backpressure, since all inputs are single-cycle strobes.
module can_dlc_payload_tracker #(
  parameter int FD_ENABLE = 1,
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_i,
  input  logic             abort_i,
  input  logic             dlc_valid_i,
  input  logic [3:0]       dlc_i,
  input  logic             fd_frame_i,
  input  logic             byte_strobe_i,
  output logic [CNT_W-1:0] data_len_o,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             last_byte_o,
  output logic             data_done_o,
  output logic [1:0]       crc_len_o,
  output logic             busy_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DONE} state_t;

  state_t state, state_nxt;

  function automatic logic [7:0] decode(input logic [3:0] d, input logic fd);
    logic [7:0] len;
    len = {4'd0, d};
    if (d > 4'd8) begin
      if (!fd) begin
        len = 8'd8;
      end else begin
        case (d)
          4'h9:    len = 8'd12;
          4'hA:    len = 8'd16;
          4'hB:    len = 8'd20;
          4'hC:    len = 8'd24;
          4'hD:    len = 8'd32;
          4'hE:    len = 8'd48;
          default: len = 8'd64;
        endcase
      end
    end
    return len;
  endfunction

  logic             fd_eff;
  logic [7:0]       dec_len;
  logic             clamp;
  logic [CNT_W-1:0] len_nxt;
  logic [1:0]       crc_nxt;
  logic             len_zero;

  assign fd_eff   = (FD_ENABLE != 0) && fd_frame_i;
  assign dec_len  = decode(dlc_i, fd_eff);
  assign clamp    = dec_len > 8'(MAX_BYTES);
  assign len_nxt  = clamp ? CNT_W'(MAX_BYTES) : CNT_W'(dec_len);
  // CRC choice follows the unclamped length: the frame on the wire is what it is.
  assign crc_nxt  = !fd_eff ? 2'd0 : ((dec_len <= 8'd16) ? 2'd1 : 2'd2);
  assign len_zero = (len_nxt == '0);

  assign busy_o      = (state == S_DATA);
  assign last_byte_o = busy_o && (byte_cnt_o == data_len_o - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_i || frame_start_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (dlc_valid_i) state_nxt = len_zero ? S_DONE : S_DATA;
        S_DATA: if (byte_strobe_i && last_byte_o) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_len_o  <= '0;
      byte_cnt_o  <= '0;
      data_done_o <= 1'b0;
      crc_len_o   <= 2'd0;
      overflow_o  <= 1'b0;
    end else begin
      data_done_o <= 1'b0;
      if (abort_i) begin
        // Length, CRC select and overflow survive an abort for error reporting.
        byte_cnt_o <= '0;
      end else if (frame_start_i) begin
        data_len_o <= '0;
        byte_cnt_o <= '0;
        overflow_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (dlc_valid_i) begin
              data_len_o  <= len_nxt;
              crc_len_o   <= crc_nxt;
              byte_cnt_o  <= '0;
              data_done_o <= len_zero;
              if (clamp) overflow_o <= 1'b1;
            end else if (byte_strobe_i) begin
              overflow_o <= 1'b1;
            end
          end
          S_DATA: begin
            if (byte_strobe_i) begin
              byte_cnt_o  <= byte_cnt_o + CNT_W'(1);
              data_done_o <= last_byte_o;
            end
          end
          default: begin
            if (byte_strobe_i) overflow_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/can_dlc_payload_tracker.md
Name: can_dlc_payload_tracker

Overview:
- Sequential successor to the combinational DLC decoder in the receive path.
- Latches the DLC when the bit-stream processor reports the control field complete, and decodes it to a byte count for classic or FD frames.
- Counts received data bytes and flags the last byte, data-field completion and the CRC length to use.
- Sits between the bit-stream processor (DLC/byte strobes) and the RX buffer write logic and CRC selector.

Parameters:
- FD_ENABLE, 1: 1 = honour fd_frame_i; 0 = every frame is decoded as classic.
- MAX_BYTES, 64: largest payload the RX buffer accepts; legal values 8..64. Decoded lengths above it are clamped and flagged.
- CNT_W, 7: width of the length and counter outputs; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- frame_start_i, input, 1: SOF pulse; re-arms the block.
- abort_i, input, 1: error/overload frame or bus-off; cancels the frame in progress.
- dlc_valid_i, input, 1: one-cycle pulse; dlc_i and fd_frame_i are valid.
- dlc_i, input, 4: raw DLC field.
- fd_frame_i, input, 1: FDF bit of the current frame.
- byte_strobe_i, input, 1: one-cycle pulse per fully received de-stuffed data byte.
- data_len_o, output, CNT_W: decoded, clamped payload length.
- byte_cnt_o, output, CNT_W: bytes received so far in the current frame.
- last_byte_o, output, 1: high while the next byte_strobe_i is the final byte.
- data_done_o, output, 1: one-cycle pulse when the data field is complete.
- crc_len_o, output, 2: CRC selector. 0 = CRC15, 1 = CRC17, 2 = CRC21; 3 is never driven.
- busy_o, output, 1: high in DATA state.
- overflow_o, output, 1: sticky. Set when the decoded length exceeds MAX_BYTES or when a byte_strobe_i arrives outside DATA. Cleared by frame_start_i.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0.
- Decode, classic (fd_frame_i=0 or FD_ENABLE=0): DLC 0..8 maps to 0..8; DLC 9..15 maps to 8.
- Decode, FD: DLC 0..8 maps to 0..8; 9..15 map to 12, 16, 20, 24, 32, 48, 64.
- Clamp: if the decoded length exceeds MAX_BYTES, data_len_o = MAX_BYTES and overflow_o is set in the same cycle the length is registered.
- crc_len_o: registered with data_len_o from the unclamped decoded value.
  - Classic frame: 0.
  - FD frame, length ≤ 16: 1.
  - FD frame, length > 16: 2.
- State IDLE:
  - On dlc_valid_i: register data_len_o and crc_len_o, clear byte_cnt_o.
  - Length 0: go to DONE and pulse data_done_o on the following cycle.
  - Otherwise: go to DATA.
  - Latency: data_len_o valid 1 cycle after dlc_valid_i.
- State DATA:
  - busy_o = 1. Each byte_strobe_i increments byte_cnt_o by 1.
  - last_byte_o = (byte_cnt_o == data_len_o − 1).
  - The strobe that takes byte_cnt_o to data_len_o moves the FSM to DONE and pulses data_done_o in the same registered cycle.
  - dlc_valid_i in DATA is ignored.
- State DONE:
  - Outputs hold (data_len_o, byte_cnt_o, crc_len_o) until frame_start_i or abort_i.
  - Extra byte_strobe_i: byte_cnt_o does not change, overflow_o is set.
- byte_strobe_i in IDLE: ignored for counting, sets overflow_o.
- Priority on simultaneous events: abort_i > frame_start_i > dlc_valid_i > byte_strobe_i.
- abort_i: forces IDLE next cycle from any state. Clears byte_cnt_o, last_byte_o and busy_o. data_len_o, crc_len_o and overflow_o hold, for error reporting. No data_done_o pulse.
- frame_start_i: forces IDLE and clears every output except crc_len_o, which holds until the next DLC.
- byte_cnt_o saturates at data_len_o; it never wraps.
- Reset asserted mid-frame: immediate return to reset values. No pulse is emitted on deassertion.

Test Plan:
- FD, DLC=4'hD, 32 byte strobes:
  - data_len_o=32 and crc_len_o=2 one cycle after dlc_valid_i.
  - last_byte_o high after the 31st strobe.
  - data_done_o pulses once on the 32nd strobe; busy_o then 0.
- Classic, DLC=4'hF, FD_ENABLE=1, fd_frame_i=0:
  - data_len_o=8, crc_len_o=0.
  - 8 strobes produce done; a 9th strobe sets overflow_o with byte_cnt_o stuck at 8.
- FD_ENABLE=0, fd_frame_i=1, DLC=4'hA: decoded as classic, data_len_o=8, crc_len_o=0.
- MAX_BYTES=16, FD DLC=4'hE:
  - data_len_o=16, crc_len_o=2, overflow_o=1.
  - done after 16 strobes.
- DLC=0, classic: FSM goes IDLE→DONE; data_done_o pulses one cycle after dlc_valid_i; byte_cnt_o=0.
- abort_i together with the 5th strobe of a 12-byte FD frame:
  - Next cycle: IDLE, byte_cnt_o=0, no data_done_o pulse.
  - Subsequent frame_start_i plus a new DLC decodes cleanly.
- rst_n pulled low mid-DATA: all outputs 0 asynchronously, with no clock edge required.
